// File: rtl/lsu_bus_split.sv
// Issues an LSU access on the 32-bit core bus as one aligned beat, or two when a half/word straddles
// a word boundary, and merges the load data. Define RV_LSU_SPLIT_TIMEOUT_EN for a beat response timeout.
module lsu_bus_split #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_store,
  input  logic [31:0] req_wdata,
  input  logic        req_sideeffect,
  input  logic        flush,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  input  logic        bus_rsp_err,
  output logic        done_valid,
  output logic [31:0] done_data,
  output logic        done_err,
  output logic [31:0] done_err_addr
);
  typedef enum logic [2:0] {
    S_IDLE, S_ISS0, S_WAIT0, S_ISS1, S_WAIT1, S_DONE
  } state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    unique case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    unique case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        split_q, split_d;
  logic        err_q, err_d;
  logic        kill_q, kill_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        store_q, store_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] d0_q, d0_d;
  logic [31:0] d1_q, d1_d;
  logic [31:0] eaddr_q, eaddr_d;

`ifdef RV_LSU_SPLIT_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
`else
  logic        unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Request decode: word index of the last byte decides split and region crossing
  logic [2:0]  req_bytes;
  logic [29:0] req_end_w;
  logic        req_mis, req_split, req_bad;

  assign req_bytes = size_bytes(req_size);
  assign req_end_w = 30'((req_addr + {29'd0, req_bytes} - 32'd1) >> 2);
  assign req_mis   = |(req_addr[1:0] & (req_bytes[1:0] - 2'd1));
  assign req_split = (req_end_w != req_addr[31:2]);
  assign req_bad   = (req_sideeffect & req_mis) | (req_addr[31:28] != req_end_w[29:26]);

  // Lane steering: the upper half of each 64-bit view belongs to the second beat
  logic [3:0]  smask;
  logic [31:0] base_addr, beat_addr, rd_word, rd_mask;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;

  assign smask     = size_mask(size_q);
  assign base_addr = {addr_q[31:2], 2'b00};
  assign beat_addr = (state_q == S_WAIT1) ? base_addr + 32'd4 : base_addr;
  assign be_wide   = {4'b0000, smask} << addr_q[1:0];
  assign wd_wide   = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
  assign rd_word   = 32'({d1_q, d0_q} >> {addr_q[1:0], 3'b000});
  assign rd_mask   = {{8{smask[3]}}, {8{smask[2]}}, {8{smask[1]}}, {8{smask[0]}}};

  always_comb begin
    state_d = state_q;
    split_d = split_q;
    err_d   = err_q;
    kill_d  = kill_q;
    addr_d  = addr_q;
    size_d  = size_q;
    store_d = store_q;
    wdata_d = wdata_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    eaddr_d = eaddr_q;
`ifdef RV_LSU_SPLIT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          addr_d  = req_addr;
          size_d  = req_size;
          store_d = req_store;
          wdata_d = req_wdata;
          split_d = req_split;
          err_d   = req_bad;
          kill_d  = 1'b0;
          eaddr_d = req_addr;
          d0_d    = '0;
          d1_d    = '0;
          state_d = req_bad ? S_DONE : S_ISS0;
        end
      end
      S_ISS0, S_ISS1: begin
        if (bus_ready) begin
          // A flush racing the handshake still owes us a response; remember to drop it
          kill_d  = flush;
          state_d = (state_q == S_ISS0) ? S_WAIT0 : S_WAIT1;
`ifdef RV_LSU_SPLIT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT0, S_WAIT1: begin
        if (bus_rsp_valid) begin
          if (kill_q || flush) begin
            state_d = S_IDLE;
          end else if (bus_rsp_err) begin
            err_d   = 1'b1;
            eaddr_d = beat_addr;
            state_d = S_DONE;
          end else if (state_q == S_WAIT0) begin
            d0_d    = bus_rsp_data;
            state_d = split_q ? S_ISS1 : S_DONE;
          end else begin
            d1_d    = bus_rsp_data;
            state_d = S_DONE;
          end
        end else begin
          kill_d = kill_q | flush;
`ifdef RV_LSU_SPLIT_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            if (kill_q || flush) begin
              state_d = S_IDLE;
            end else begin
              err_d   = 1'b1;
              eaddr_d = beat_addr;
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
`ifdef RV_LSU_SPLIT_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      split_q <= split_d;
      err_q   <= err_d;
      kill_q  <= kill_d;
`ifdef RV_LSU_SPLIT_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Payload registers are only observed through state-gated outputs, so they carry no reset
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    store_q <= store_d;
    wdata_q <= wdata_d;
    d0_q    <= d0_d;
    d1_q    <= d1_d;
    eaddr_q <= eaddr_d;
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE);
    bus_valid     = 1'b0;
    bus_addr      = '0;
    bus_byteen    = '0;
    bus_write     = 1'b0;
    bus_wdata     = '0;
    done_valid    = 1'b0;
    done_data     = '0;
    done_err      = 1'b0;
    done_err_addr = '0;
    unique case (state_q)
      S_ISS0: begin
        bus_valid  = 1'b1;
        bus_addr   = base_addr;
        bus_byteen = be_wide[3:0];
        bus_write  = store_q;
        bus_wdata  = wd_wide[31:0];
      end
      S_ISS1: begin
        bus_valid  = 1'b1;
        bus_addr   = base_addr + 32'd4;
        bus_byteen = be_wide[7:4];
        bus_write  = store_q;
        bus_wdata  = wd_wide[63:32];
      end
      S_DONE: begin
        done_valid    = 1'b1;
        done_err      = err_q;
        done_err_addr = err_q ? eaddr_q : 32'd0;
        done_data     = (err_q || store_q) ? 32'd0 : (rd_word & rd_mask);
      end
      default: ;
    endcase
  end
endmodule
